// File: rtl/game_pkg.sv
// Shared types for the multi-player light-cycle move engine: directions, map
// tiles, engine states and the player limit.
package game_pkg;

  localparam int MAX_PLAYERS = 4;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } directions;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    FRAME   = 3'd1,
    PLAYER1 = 3'd2,
    PLAYER2 = 3'd3,
    PLAYER3 = 3'd4,
    PLAYER4 = 3'd5
  } tile;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SPAWN = 3'd2,
    RUN   = 3'd3,
    STEP  = 3'd4,
    OVER  = 3'd5
  } engine_state;

  function automatic directions reverse_of(directions d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return WAIT;
    endcase
  endfunction

  function automatic tile player_tile(int p);
    return tile'(3'(p + 2));
  endfunction

endpackage

// File: rtl/multi_player_move_engine_move_target_calc.sv
// Per-player heading filter and next-cell calculator (combinational).
// WRAP_AROUND_EN selects toroidal wrap at the map edges.
module move_target_calc
  import game_pkg::*;
#(
  parameter int MAP_WIDTH  = 32,
  parameter int MAP_HEIGHT = 24,
  localparam int XW = $clog2(MAP_WIDTH),
  localparam int YW = $clog2(MAP_HEIGHT)
) (
  input  logic [XW-1:0] pos_x,
  input  logic [YW-1:0] pos_y,
  input  directions     heading,
  input  directions     dir_in,
  output directions     next_heading,
  output logic [XW-1:0] tgt_x,
  output logic [YW-1:0] tgt_y
);

  always_comb begin
    next_heading = heading;
    // WAIT keeps the heading; reversing into our own trail is ignored.
    if (dir_in != WAIT && dir_in != reverse_of(heading)) next_heading = dir_in;

    tgt_x = pos_x;
    tgt_y = pos_y;
    case (next_heading)
`ifdef WRAP_AROUND_EN
      UP:    tgt_y = (pos_y == '0) ? YW'(MAP_HEIGHT - 1) : pos_y - YW'(1);
      DOWN:  tgt_y = (pos_y == YW'(MAP_HEIGHT - 1)) ? '0 : pos_y + YW'(1);
      LEFT:  tgt_x = (pos_x == '0) ? XW'(MAP_WIDTH - 1) : pos_x - XW'(1);
      RIGHT: tgt_x = (pos_x == XW'(MAP_WIDTH - 1)) ? '0 : pos_x + XW'(1);
`else
      UP:    tgt_y = pos_y - YW'(1);
      DOWN:  tgt_y = pos_y + YW'(1);
      LEFT:  tgt_x = pos_x - XW'(1);
      RIGHT: tgt_x = pos_x + XW'(1);
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_player_move_engine.sv
// Tile map owner and move engine for 2..4 light-cycle players.
// Define WRAP_AROUND_EN to drop the FRAME border and wrap movement at the edges.
module multi_player_move_engine
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int MAP_WIDTH   = 32,
  parameter int MAP_HEIGHT  = 24,
  parameter int MOVE_DIV    = 4,
  localparam int XW = $clog2(MAP_WIDTH),
  localparam int YW = $clog2(MAP_HEIGHT),
  localparam int TW = $clog2(MOVE_DIV)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  directions              dir_in [NUM_PLAYERS],
  input  logic [XW-1:0]          rd_x,
  input  logic [YW-1:0]          rd_y,
  output tile                    rd_tile,
  output logic [NUM_PLAYERS-1:0] alive,
  output logic [NUM_PLAYERS-1:0] collision,
  output logic                   busy,
  output logic                   game_over,
  output logic [2:0]             winner
);

  engine_state          state_q, state_d;
  logic [YW-1:0]        row_q, row_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [XW-1:0]        pos_x_q [NUM_PLAYERS];
  logic [XW-1:0]        pos_x_d [NUM_PLAYERS];
  logic [YW-1:0]        pos_y_q [NUM_PLAYERS];
  logic [YW-1:0]        pos_y_d [NUM_PLAYERS];
  directions            heading_q [NUM_PLAYERS];
  directions            heading_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] alive_q, alive_d, collision_q, collision_d;
  logic [2:0]           winner_q, winner_d;

  tile                  map_mem [MAP_WIDTH][MAP_HEIGHT];

  directions            nxt_hd [NUM_PLAYERS];
  logic [XW-1:0]        tgt_x  [NUM_PLAYERS];
  logic [YW-1:0]        tgt_y  [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] mover, blocked, head_on, dies, wr_en;
  logic [XW-1:0]        wr_x [NUM_PLAYERS];
  logic [YW-1:0]        wr_y [NUM_PLAYERS];
  logic [2:0]           live_cnt, live_last;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_calc
    move_target_calc #(
      .MAP_WIDTH (MAP_WIDTH),
      .MAP_HEIGHT(MAP_HEIGHT)
    ) u_calc (
      .pos_x       (pos_x_q[p]),
      .pos_y       (pos_y_q[p]),
      .heading     (heading_q[p]),
      .dir_in      (dir_in[p]),
      .next_heading(nxt_hd[p]),
      .tgt_x       (tgt_x[p]),
      .tgt_y       (tgt_y[p])
    );
  end

  function automatic tile clear_tile(int x, logic [YW-1:0] y);
`ifdef WRAP_AROUND_EN
    return EMPTY;
`else
    if (x == 0 || x == MAP_WIDTH - 1 || y == '0 || y == YW'(MAP_HEIGHT - 1)) return FRAME;
    return EMPTY;
`endif
  endfunction

  // A player dies on a non-empty target or when sharing its target with another mover.
  always_comb begin
    mover   = '0;
    blocked = '0;
    head_on = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) mover[p] = alive_q[p] && (nxt_hd[p] != WAIT);
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      blocked[p] = mover[p] && (map_mem[tgt_x[p]][tgt_y[p]] != EMPTY);
      for (int q = 0; q < NUM_PLAYERS; q++) begin
        if (q != p && mover[p] && mover[q] && tgt_x[q] == tgt_x[p] && tgt_y[q] == tgt_y[p])
          head_on[p] = 1'b1;
      end
    end
    dies = blocked | head_on;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    row_d       = row_q;
    tick_d      = tick_q;
    alive_d     = alive_q;
    collision_d = '0;
    winner_d    = winner_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    heading_d   = heading_q;
    wr_en       = '0;
    wr_x        = pos_x_q;
    wr_y        = pos_y_q;
    live_cnt    = '0;
    live_last   = '0;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d  = CLEAR;
          row_d    = '0;
          winner_d = '0;
        end
      end
      CLEAR: begin
        row_d = row_q + YW'(1);
        if (row_q == YW'(MAP_HEIGHT - 1)) state_d = SPAWN;
      end
      SPAWN: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          pos_x_d[p]   = XW'((p + 1) * MAP_WIDTH / (NUM_PLAYERS + 1));
          pos_y_d[p]   = YW'(MAP_HEIGHT / 2);
          heading_d[p] = WAIT;
          wr_en[p]     = 1'b1;
          wr_x[p]      = pos_x_d[p];
          wr_y[p]      = pos_y_d[p];
        end
        alive_d = '1;
        tick_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (tick_q == TW'(MOVE_DIV - 1)) begin
          tick_d  = '0;
          state_d = STEP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      STEP: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          heading_d[p] = nxt_hd[p];
          if (mover[p] && !dies[p]) begin
            pos_x_d[p] = tgt_x[p];
            pos_y_d[p] = tgt_y[p];
            wr_en[p]   = 1'b1;
            wr_x[p]    = tgt_x[p];
            wr_y[p]    = tgt_y[p];
          end
        end
        alive_d     = alive_q & ~dies;
        collision_d = dies;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (alive_d[p]) begin
            live_cnt  = live_cnt + 3'd1;
            live_last = 3'(p);
          end
        end
        if (live_cnt <= 3'd1) begin
          state_d  = OVER;
          winner_d = (live_cnt == 3'd1) ? live_last + 3'd1 : 3'd0;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      tick_q      <= '0;
      alive_q     <= '0;
      collision_q <= '0;
      winner_q    <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        pos_x_q[p]   <= '0;
        pos_y_q[p]   <= '0;
        heading_q[p] <= WAIT;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      tick_q      <= tick_d;
      alive_q     <= alive_d;
      collision_q <= collision_d;
      winner_q    <= winner_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      heading_q   <= heading_d;
    end
  end

  // NOTE: the map has no reset; CLEAR initialises it and IDLE masks its contents on rd_tile.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        for (int x = 0; x < MAP_WIDTH; x++) map_mem[x][row_q] <= clear_tile(x, row_q);
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (wr_en[p]) map_mem[wr_x[p]][wr_y[p]] <= player_tile(p);
      end
    end
  end

  always_comb begin
    rd_tile = EMPTY;
    if (state_q != IDLE && int'(rd_x) < MAP_WIDTH && int'(rd_y) < MAP_HEIGHT)
      rd_tile = map_mem[rd_x][rd_y];
  end

  assign alive     = alive_q;
  assign collision = collision_q;
  assign busy      = (state_q == CLEAR) || (state_q == SPAWN) || (state_q == RUN);
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;

endmodule
